// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the shared-port RV32I core.
// It steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It decides when the
// IR, PC and register file are written, and when memory requests are raised.
// It counts retired instructions. It halts on an illegal opcode, on ECALL/EBREAK,
// or when a memory ack does not arrive in time.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opecode,
  input  logic [2:0]       func3,
  input  logic [1:0]       COMPRes,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // The counter holds the number of ack-less cycles already spent in this state.
  // The request times out on the cycle that would make it reach MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_r;
  state_t           next_s;
  logic [7:0]       wait_cnt_r;
  logic [1:0]       halt_cause_r;
  logic [1:0]       cause_next_s;
  logic             halted_r;
  logic [CNT_W-1:0] retire_cnt_r;

  logic is_load_s, is_store_s, is_branch_s, is_jal_s, is_jalr_s;
  logic is_system_s, is_alu_s, legal_s;

  logic imem_req_s, dmem_req_s, dmem_we_s, ir_we_s, pc_we_s, reg_we_s, pc_sel_s;

  // Branch condition from func3 and the comparator result (00 eq, 01 less).
  function automatic logic branch_taken(input logic [2:0] f3, input logic [1:0] cmp);
    logic eq_v;
    logic lt_v;
    logic tk_v;
    eq_v = (cmp == 2'b00);
    lt_v = (cmp == 2'b01);
    case (f3)
      3'b000:         tk_v = eq_v;
      3'b001:         tk_v = !eq_v;
      3'b100, 3'b110: tk_v = lt_v;
      3'b101, 3'b111: tk_v = !lt_v;
      default:        tk_v = 1'b0;
    endcase
    return tk_v;
  endfunction

  // Classify the latched instruction by its major opcode.
  always_comb begin
    is_load_s   = 1'b0;
    is_store_s  = 1'b0;
    is_branch_s = 1'b0;
    is_jal_s    = 1'b0;
    is_jalr_s   = 1'b0;
    is_system_s = 1'b0;
    is_alu_s    = 1'b0;
    if (opecode[1:0] == 2'b11) begin
      case (opecode[6:2])
        5'b00000: is_load_s   = 1'b1;
        5'b01000: is_store_s  = 1'b1;
        5'b11000: is_branch_s = 1'b1;
        5'b11011: is_jal_s    = 1'b1;
        5'b11001: is_jalr_s   = 1'b1;
        5'b11100: is_system_s = 1'b1;
        5'b01100, 5'b00100, 5'b01101, 5'b00101: is_alu_s = 1'b1;
        default: is_alu_s = 1'b0;
      endcase
    end else begin
      is_alu_s = 1'b0;
    end
    legal_s = is_load_s | is_store_s | is_branch_s | is_jal_s | is_jalr_s |
              is_system_s | is_alu_s;
  end

  // Next-state, halt cause and raw strobe decode for the current state.
  always_comb begin
    next_s       = state_r;
    cause_next_s = halt_cause_r;
    imem_req_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    pc_sel_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          ir_we_s = 1'b1;
          next_s  = S_DECODE;
        end else if (wait_cnt_r >= WAIT_LAST) begin
          next_s       = S_HALT;
          cause_next_s = CAUSE_TIMEOUT;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!legal_s) begin
          next_s       = S_HALT;
          cause_next_s = CAUSE_ILLEGAL;
        end else if (is_system_s) begin
          next_s       = S_HALT;
          cause_next_s = CAUSE_SYSTEM;
        end else begin
          next_s = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load_s || is_store_s) begin
          next_s = S_MEM;
        end else if (is_branch_s) begin
          pc_we_s  = 1'b1;
          pc_sel_s = branch_taken(func3, COMPRes);
          next_s   = S_FETCH;
        end else begin
          next_s = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = is_store_s;
        if (dmem_ack) begin
          if (is_store_s) begin
            pc_we_s = 1'b1;
            next_s  = S_FETCH;
          end else begin
            next_s = S_WB;
          end
        end else if (wait_cnt_r >= WAIT_LAST) begin
          next_s       = S_HALT;
          cause_next_s = CAUSE_TIMEOUT;
        end else begin
          next_s = S_MEM;
        end
      end
      S_WB: begin
        reg_we_s = 1'b1;
        pc_we_s  = 1'b1;
        pc_sel_s = is_jal_s | is_jalr_s;
        next_s   = S_FETCH;
      end
      S_HALT: begin
        next_s = S_HALT;
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Strobes are killed combinationally while reset is held, so an abandoned request drops at once.
  always_comb begin
    imem_req = rst_n & imem_req_s;
    dmem_req = rst_n & dmem_req_s;
    dmem_we  = rst_n & dmem_we_s;
    ir_we    = rst_n & ir_we_s;
    pc_we    = rst_n & pc_we_s;
    reg_we   = rst_n & reg_we_s;
    pc_sel   = pc_sel_s;
  end

  // State, wait counter, halt status and retire counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_FETCH;
      wait_cnt_r   <= 8'd0;
      halt_cause_r <= 2'b00;
      halted_r     <= 1'b0;
      retire_cnt_r <= '0;
    end else begin
      state_r      <= next_s;
      halt_cause_r <= cause_next_s;
      halted_r     <= (next_s == S_HALT);
      if (next_s != state_r) begin
        wait_cnt_r <= 8'd0;
      end else if ((state_r == S_FETCH && !imem_ack) || (state_r == S_MEM && !dmem_ack)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (pc_we_s) begin
        retire_cnt_r <= retire_cnt_r + CNT_W'(1);
      end else begin
        retire_cnt_r <= retire_cnt_r;
      end
    end
  end

  assign state      = state_r;
  assign halted     = halted_r;
  assign halt_cause = halt_cause_r;
  assign retire_cnt = retire_cnt_r;

endmodule
